data_ram_hs: RTL and testbench

DATA_RAM_HS -- requirements
Module: data_ram_hs

---
 rtl/data_ram_pkg.sv | 13 +
 rtl/data_ram_hs_wait_cnt.sv | 32 +++
 rtl/data_ram_hs.sv | 158 +++++++++++++++
 tb/tb_data_ram_hs.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared constants for the handshaked data RAM.
// FSM encodings and default geometry.
package data_ram_pkg;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned DEPTH_DEF       = 1024;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/data_ram_hs_wait_cnt.sv
// Wait-state counter for data_ram_hs.
// done rises after WAIT_CYCLES counted cycles.
module ram_wait_cnt
    import data_ram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam logic [3:0] LAST =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && !done) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/data_ram_hs.sv
// Word-organised data RAM behind a valid/ready request/response pair.
// Fixed wait states per transaction, byte strobes, range/alignment check.
module data_ram_hs
    import data_ram_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * NB);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              bubble;
    logic              accept;
    logic              handshake;
    logic              go_resp;
    logic              wait_done;
    logic              mem_we;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_be;

    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [NB-1:0]     a_be;
    logic [IDX_W-1:0]  a_idx;
    logic              a_err;

    assign req_ready = (state == ST_IDLE) && !bubble;
    assign accept    = req_valid && req_ready;
    assign handshake = rsp_valid && rsp_ready;

    // Without wait states the access happens on the accept edge itself,
    // so the live request is used instead of the captured copy.
    always_comb begin
        if (state == ST_IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_be    = req_be;
        end else begin
            a_we    = r_we;
            a_addr  = r_addr;
            a_wdata = r_wdata;
            a_be    = r_be;
        end
    end

    assign a_idx = a_addr[OFF_W +: IDX_W];
    assign a_err = ((a_addr & ADDR_W'(NB - 1)) != '0)
                || ({1'b0, a_addr} >= LIMIT);

    always_comb begin
        state_nx = state;
        go_resp  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (NO_WAIT) begin
                        state_nx = ST_RESP;
                        go_resp  = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_nx = ST_RESP;
                    go_resp  = 1'b1;
                end
            end
            ST_RESP: begin
                if (handshake) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    ram_wait_cnt #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .count(state == ST_WAIT),
        .done (wait_done)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    assign mem_we = go_resp && a_we && !a_err && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (a_be[b]) begin
                    mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bubble    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state  <= state_nx;
            bubble <= handshake;
            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= a_err;
                rsp_rdata <= (a_we || a_err) ? '0 : mem[a_idx];
            end else if (handshake) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_ram_hs.sv
// Directed self-checking bench for data_ram_hs.
// Covers the default two-wait-state build and a zero-wait build.
module tb_data_ram_hs;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int passes = 0;

    logic        zv_we  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] zv_addr[4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] zv_wd  [4] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0, 32'h0};
    logic [31:0] zv_exp [4] = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h0F0F0F0F};

    always #5 clk = ~clk;

    data_ram_hs u_dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    data_ram_hs #(
        .WAIT_CYCLES(0)
    ) u_dut_z (
        .clk      (clk),
        .reset    (reset),
        .req_valid(z_req_valid),
        .req_ready(z_req_ready),
        .req_we   (z_req_we),
        .req_addr (z_req_addr),
        .req_wdata(z_req_wdata),
        .req_be   (z_req_be),
        .rsp_valid(z_rsp_valid),
        .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata),
        .rsp_err  (z_rsp_err)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int hold, input string tag);
        int n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk(32'(req_ready), 32'd1, {tag, "_ready"});
        step();
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = '1;
        req_wdata = ~wdata;
        req_be    = ~be;
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk(32'(n), 32'd3, {tag, "_lat"});
        chk(rsp_rdata, exp_rdata, {tag, "_rdata"});
        chk(32'(rsp_err), 32'(exp_err), {tag, "_err"});
        for (int i = 0; i < hold; i++) begin
            step();
            chk(32'(rsp_valid), 32'd1, {tag, "_hold_valid"});
            chk(rsp_rdata, exp_rdata, {tag, "_hold_rdata"});
            chk(32'(rsp_err), 32'(exp_err), {tag, "_hold_err"});
            chk(32'(req_ready), 32'd0, {tag, "_hold_ready"});
        end
        rsp_ready = 1'b1;
        step();
        chk(32'(rsp_valid), 32'd0, {tag, "_drop"});
        chk(32'(req_ready), 32'd0, {tag, "_bubble"});
        step();
        chk(32'(req_ready), 32'd1, {tag, "_back"});
    endtask

    initial begin
        int k;
        int acc_t;
        logic acc;
        logic seen;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        rsp_ready   = 1'b1;
        z_req_valid = 1'b0;
        z_req_we    = 1'b0;
        z_req_addr  = '0;
        z_req_wdata = '0;
        z_req_be    = 4'hF;
        z_rsp_ready = 1'b1;

        repeat (3) step();
        chk(32'(rsp_valid), 32'd0, "rst_valid");
        chk(rsp_rdata, 32'd0, "rst_rdata");
        chk(32'(rsp_err), 32'd0, "rst_err");
        reset = 1'b0;
        step();
        chk(32'(req_ready), 32'd1, "rst_ready");

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, "wr_full");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0, "rd_full");
        txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 0, "wr_b0");
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, "rd_merge");
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0, "wr_nobe");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0, 0, "rd_nobe");

        txn(1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, 0, "rd_mis");
        txn(1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 0, "rd_oob");
        txn(1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0, 1'b0, 0, "wr_w0");
        txn(1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1, 0, "wr_oob");
        txn(1'b1, 32'h12, 32'hBAD1BAD1, 4'hF, 32'h0, 1'b1, 0, "wr_mis");
        txn(1'b0, 32'h0, 32'h0, 4'hF, 32'h11111111, 1'b0, 0, "rd_w0");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0, 0, "rd_keep");

        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0, 5, "stall");

        txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0, "wr_20");
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        reset     = 1'b1;
        step();
        chk(32'(rsp_valid), 32'd0, "wrst_valid");
        chk(32'(rsp_err), 32'd0, "wrst_err");
        chk(rsp_rdata, 32'd0, "wrst_rdata");
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | rsp_valid;
        end
        chk(32'(seen), 32'd0, "wrst_norsp");
        txn(1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0, "rd_20");

        k     = 0;
        acc_t = 0;
        z_req_we    = zv_we[0];
        z_req_addr  = zv_addr[0];
        z_req_wdata = zv_wd[0];
        z_req_valid = 1'b1;
        for (int t = 0; t < 40 && k < 4; t++) begin
            acc = z_req_valid && z_req_ready;
            step();
            if (acc) begin
                chk(32'(z_rsp_valid), 32'd1, "z_lat");
                chk(z_rsp_rdata, zv_exp[k], "z_rdata");
                if (k > 0) begin
                    chk(32'(t - acc_t), 32'd3, "z_gap");
                end
                acc_t = t;
                k++;
                if (k < 4) begin
                    z_req_we    = zv_we[k];
                    z_req_addr  = zv_addr[k];
                    z_req_wdata = zv_wd[k];
                end else begin
                    z_req_valid = 1'b0;
                end
            end
        end
        chk(32'(k), 32'd4, "z_done");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
